wshb_stream_sink: RTL and testbench

- Wishbone responder for the video stream master port of hw_support (wshb_if_stream). It replaces the constant ack/dat_sm/err/rty tie-offs.
- Accepts pixel write cycles on sys_clk and buffers them in a FIFO.
- Re-issues the buffered pixels as Wishbone write cycles toward the framebuffer, through a new port on wshb_intercon.
- Pixels are written at linear addresses BASE_ADDR + 4*pixel_index. The index wraps every HDISP*VDISP pixels.

---
 rtl/wshb_stream_sink.sv | 169 ++++++++++++++++
 tb/tb_wshb_stream_sink.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wshb_stream_sink.sv
`default_nettype none
// ============================================================================
//  Module   : wshb_stream_sink
//  Purpose  : Wishbone responder for the video stream port. Buffers incoming
//             pixel writes in a FIFO and replays them as Wishbone writes to
//             the framebuffer at BASE_ADDR + 4*pixel_index.
//  Revision : 1.0  initial release
// ============================================================================
module wshb_stream_sink #(
    parameter int          HDISP      = 800,
    parameter int          VDISP      = 480,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst,
    // stream (slave) side
    input  logic                            s_cyc,
    input  logic                            s_stb,
    input  logic                            s_we,
    input  logic [31:0]                     s_adr,
    input  logic [31:0]                     s_dat_ms,
    output logic [31:0]                     s_dat_sm,
    output logic                            s_ack,
    output logic                            s_err,
    output logic                            s_rty,
    // framebuffer (master) side
    output logic                            m_cyc,
    output logic                            m_stb,
    output logic                            m_we,
    output logic [31:0]                     m_adr,
    output logic [31:0]                     m_dat_ms,
    output logic [3:0]                      m_sel,
    input  logic                            m_ack,
    // status
    output logic [15:0]                     frame_cnt,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int          c_AW         = $clog2(FIFO_DEPTH);
    localparam int          c_TOTAL      = HDISP * VDISP;
    localparam int          c_IW         = $clog2(c_TOTAL);
    localparam logic [31:0] c_TOTAL_W    = 32'(c_TOTAL);
    localparam logic [c_AW:0] c_FULL_LEVEL = (c_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t             r_state;
    logic [32:0]        r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_AW:0]      r_level;
    logic [c_IW-1:0]    r_pixel_index;
    logic               r_sof;
    logic [15:0]        r_frame_cnt;
    logic               r_m_cyc;
    logic [31:0]        r_m_adr;
    logic [31:0]        r_m_dat;

    logic               w_req;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic [32:0]        w_head;
    logic [31:0]        w_head_index;
    logic [31:0]        w_head_adr;
    logic [31:0]        w_next_index;
    logic               w_wrap;

    // Requests are masked during reset so nothing is acked that reset discards.
    assign w_req   = s_cyc & s_stb & ~sys_rst;
    assign w_pop   = (r_state == S_WRITE) & m_ack;
    assign w_full  = (r_level == c_FULL_LEVEL);
    assign w_empty = (r_level == '0);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push  = w_req & s_we & (~w_full | w_pop);

    assign s_ack    = w_push;
    assign s_err    = w_req & ~s_we;
    assign s_rty    = 1'b0;
    assign s_dat_sm = 32'h0;

    // Start-of-frame entries restart the index at zero, abandoning any partial frame.
    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_index = w_head[32] ? 32'd0 : 32'(r_pixel_index);
    assign w_head_adr   = BASE_ADDR + (w_head_index << 2);
    assign w_next_index = (r_sof ? 32'd0 : 32'(r_pixel_index)) + 32'd1;
    assign w_wrap       = (w_next_index == c_TOTAL_W);

    // FIFO storage: {sof, pixel} written at the tail on accept.
    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {(s_adr == 32'd0), s_dat_ms};
        end
    end

    // FIFO pointers and registered occupancy.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Master FSM: latch the FIFO head, then hold the write until acknowledged.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state       <= S_IDLE;
            r_m_cyc       <= 1'b0;
            r_m_adr       <= 32'h0;
            r_m_dat       <= 32'h0;
            r_sof         <= 1'b0;
            r_pixel_index <= '0;
            r_frame_cnt   <= 16'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_m_adr <= w_head_adr;
                        r_m_dat <= w_head[31:0];
                        r_sof   <= w_head[32];
                        r_m_cyc <= 1'b1;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (m_ack) begin
                        r_m_cyc <= 1'b0;
                        r_state <= S_IDLE;
                        if (w_wrap) begin
                            r_pixel_index <= '0;
                            r_frame_cnt   <= r_frame_cnt + 16'd1;
                        end else begin
                            r_pixel_index <= w_next_index[c_IW-1:0];
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_m_cyc <= 1'b0;
                end
            endcase
        end
    end

    assign m_cyc      = r_m_cyc;
    assign m_stb      = r_m_cyc;
    assign m_we       = 1'b1;
    assign m_sel      = 4'hF;
    assign m_adr      = r_m_adr;
    assign m_dat_ms   = r_m_dat;
    assign frame_cnt  = r_frame_cnt;
    assign fifo_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_wshb_stream_sink.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wshb_stream_sink
//  Purpose  : Scoreboard bench for wshb_stream_sink with a small frame model.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_wshb_stream_sink;

    localparam int          HDISP      = 4;
    localparam int          VDISP      = 2;
    localparam int          FIFO_DEPTH = 16;
    localparam logic [31:0] BASE_ADDR  = 32'h0010_0000;
    localparam int          TOTAL      = HDISP * VDISP;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        s_cyc = 1'b0, s_stb = 1'b0, s_we = 1'b0;
    logic [31:0] s_adr = 32'h0, s_dat_ms = 32'h0;
    logic [31:0] s_dat_sm;
    logic        s_ack, s_err, s_rty;
    logic        m_cyc, m_stb, m_we;
    logic [31:0] m_adr, m_dat_ms;
    logic [3:0]  m_sel;
    logic        m_ack = 1'b0;
    logic [15:0] frame_cnt;
    logic [4:0]  fifo_level;

    wshb_stream_sink #(
        .HDISP(HDISP), .VDISP(VDISP), .FIFO_DEPTH(FIFO_DEPTH), .BASE_ADDR(BASE_ADDR)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_ms(s_dat_ms),
        .s_dat_sm(s_dat_sm), .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_ms(m_dat_ms),
        .m_sel(m_sel), .m_ack(m_ack),
        .frame_cnt(frame_cnt), .fifo_level(fifo_level)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [15:0] frame;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          ack_mode = 0;   // 0: m_ack low, 1: m_ack high, 2: random
    int unsigned m_idx = 0;
    int unsigned m_frames = 0;
    logic [15:0] pend_frame;
    bit          frame_chk = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: each accepted pixel gets its framebuffer address and the
    // frame count that must be visible once it has been written.
    task automatic model_accept(input logic [31:0] adr, input logic [31:0] dat);
        exp_t e;
        int unsigned base_idx;
        base_idx = (adr == 32'h0) ? 0 : m_idx;
        e.adr = BASE_ADDR + 32'(base_idx * 4);
        m_idx = base_idx + 1;
        if (m_idx == TOTAL) begin
            m_idx    = 0;
            m_frames = (m_frames + 1) % 65536;
        end
        e.dat   = dat;
        e.frame = 16'(m_frames);
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_idx    = 0;
        m_frames = 0;
    endtask

    // m_ack driver, updated 2 ns after each rising edge.
    always @(posedge sys_clk) begin
        #2;
        m_ack = (ack_mode == 2) ? 1'($urandom_range(0, 1)) : (ack_mode == 1);
    end

    // Monitor: pops the scoreboard on every completed master write.
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            frame_chk = 0;
        end else begin
            if (frame_chk) begin
                check("frame_cnt", 32'(frame_cnt), 32'(pend_frame));
                frame_chk = 0;
            end
            if (m_cyc && m_stb && m_ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_master_write", 32'(m_adr), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("m_adr", m_adr, e.adr);
                    check("m_dat_ms", m_dat_ms, e.dat);
                    check("m_we_sel", {27'h0, m_we, m_sel}, 32'h1F);
                    pend_frame = e.frame;
                    frame_chk  = 1;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1.
    task automatic do_write(input logic [31:0] adr, input logic [31:0] dat,
                            input int max_cycles, output bit acked);
        acked = 0;
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_adr = adr; s_dat_ms = dat;
        for (int i = 0; i < max_cycles && !acked; i++) begin
            @(negedge sys_clk);
            if (s_ack) begin
                acked = 1;
                model_accept(adr, dat);
            end
            @(posedge sys_clk); #1;
        end
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        bit done;
        done = 0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            @(negedge sys_clk);
            done = (fifo_level == 5'd0) && !m_cyc && (exp_q.size() == 0);
        end
        check("drain_complete", 32'(done), 32'h1);
        @(posedge sys_clk); #1;
    endtask

    task automatic apply_reset();
        sys_rst = 1'b1;
        model_reset();
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
    endtask

    initial begin
        bit ok;
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        // Reset state
        @(posedge sys_clk); #1;
        apply_reset();
        @(negedge sys_clk);
        check("rst_s_ack_err", {30'h0, s_ack, s_err}, 32'h0);
        check("rst_m_cyc_stb", {30'h0, m_cyc, m_stb}, 32'h0);
        check("rst_fifo_level", 32'(fifo_level), 32'h0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'h0);
        check("const_outputs", {s_dat_sm[30:0], s_rty}, 32'h0);
        @(posedge sys_clk); #1;

        // Three writes with m_ack tied high
        ack_mode = 1;
        do_write(32'h0, 32'hA, 1, ok); check("basic_ack0", 32'(ok), 32'h1);
        do_write(32'h4, 32'hB, 1, ok); check("basic_ack1", 32'(ok), 32'h1);
        do_write(32'h8, 32'hC, 1, ok); check("basic_ack2", 32'(ok), 32'h1);
        drain(50);

        // Fill the FIFO with m_ack held low
        ack_mode = 0;
        for (int i = 0; i < 16; i++) begin
            do_write(32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 1, ok);
            check("fill_ack", 32'(ok), 32'h1);
        end
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_adr = 32'h200; s_dat_ms = 32'h2010;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            check("full_no_ack", {30'h0, s_ack, s_err}, 32'h0);
            check("full_level", 32'(fifo_level), 32'd16);
            @(posedge sys_clk); #1;
        end
        // Release m_ack: the pending write is accepted in the same cycle as the pop
        ack_mode = 1;
        @(negedge sys_clk);
        check("full_simul_ack", 32'(s_ack), 32'h1);
        if (s_ack) model_accept(s_adr, s_dat_ms);
        @(posedge sys_clk); #1;
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        @(negedge sys_clk);
        check("full_simul_level", 32'(fifo_level), 32'd16);
        @(posedge sys_clk); #1;
        for (int i = 0; i < 3; i++) begin
            do_write(32'h204 + 32'(4 * i), 32'h2011 + 32'(i), 10, ok);
            check("refill_ack", 32'(ok), 32'h1);
        end
        drain(200);

        // Frame wrap: 8 pixels then 3 more
        apply_reset();
        ack_mode = 2;
        for (int i = 0; i < 11; i++) begin
            do_write(32'(4 * i), 32'h3000 + 32'(i), 10, ok);
            check("wrap_ack", 32'(ok), 32'h1);
        end
        drain(200);
        check("wrap_frame_cnt", 32'(frame_cnt), 32'd1);

        // Frame restart mid-frame
        for (int i = 0; i < 3; i++) begin
            do_write(32'h40 + 32'(4 * i), 32'h4000 + 32'(i), 10, ok);
            check("restart_pre_ack", 32'(ok), 32'h1);
        end
        for (int i = 0; i < 3; i++) begin
            do_write(32'(4 * i), 32'h4100 + 32'(i), 10, ok);
            check("restart_ack", 32'(ok), 32'h1);
        end
        drain(200);
        check("restart_frame_cnt", 32'(frame_cnt), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            logic [31:0] adr;
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(posedge sys_clk); #1;
            end
            adr = ($urandom_range(0, 9) == 0) ? 32'h0 : ($urandom | 32'h4);
            do_write(adr, $urandom, 60, ok);
            check("rand_ack", 32'(ok), 32'h1);
        end
        drain(400);

        // Read cycle
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_adr = 32'h10;
        @(negedge sys_clk);
        check("read_err_ack", {30'h0, s_ack, s_err}, 32'h1);
        @(posedge sys_clk); #1;
        s_cyc = 1'b0; s_stb = 1'b0;
        @(negedge sys_clk);
        check("read_no_push", {26'h0, m_cyc, fifo_level}, 32'h0);
        check("read_err_cleared", 32'(s_err), 32'h0);
        @(posedge sys_clk); #1;

        // Reset while a master write is outstanding
        ack_mode = 0;
        for (int i = 0; i < 6; i++) begin
            do_write(32'h80 + 32'(4 * i), 32'h5000 + 32'(i), 1, ok);
            check("prerst_ack", 32'(ok), 32'h1);
        end
        @(negedge sys_clk);
        check("prerst_m_cyc", 32'(m_cyc), 32'h1);
        check("prerst_level", 32'(fifo_level), 32'd6);
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        model_reset();
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("midrst_m_cyc", 32'(m_cyc), 32'h0);
        check("midrst_level", 32'(fifo_level), 32'h0);
        check("midrst_frame", 32'(frame_cnt), 32'h0);
        @(posedge sys_clk); #1;

        // First write after reset does not need a start-of-frame address
        ack_mode = 1;
        do_write(32'h40, 32'h6000, 2, ok);
        check("postrst_ack", 32'(ok), 32'h1);
        drain(50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
